// File: rtl/icache_controller.sv
// Direct-mapped read-only instruction cache between fetch and 128-bit line memory.
// One lookup cycle per request; misses fill a whole line over a req/ready handshake.
module icache_controller #(
  parameter int INDEX_BITS = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cpu_req,
  input  logic [31:0]      cpu_addr,
  output logic             cpu_ready,
  output logic [31:0]      cpu_data,
  input  logic             flush,
  output logic             mem_req,
  output logic [31:0]      mem_addr,
  input  logic             mem_ready,
  input  logic [127:0]     mem_line,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = 28 - INDEX_BITS;

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    FILL
  } state_t;

  state_t state_q, state_d;

  logic [31:0]           req_addr;
  logic [LINES-1:0]      valid_q;
  logic [TAG_W-1:0]      tag_q  [LINES];
  logic [127:0]          data_q [LINES];

  logic [INDEX_BITS-1:0] idx;
  logic [TAG_W-1:0]      tg;
  logic [1:0]            wsel;
  logic                  hit;

  assign idx  = req_addr[4+INDEX_BITS-1:4];
  assign tg   = req_addr[31:4+INDEX_BITS];
  assign wsel = req_addr[3:2];
  assign hit  = valid_q[idx] && (tag_q[idx] == tg);

  function automatic logic [31:0] pick(
    input logic [127:0] line,
    input logic [1:0]   w
  );
    return line[32*w +: 32];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (!flush && cpu_req) state_d = LOOKUP;
      LOOKUP:  state_d = hit ? IDLE : FILL;
      FILL:    if (mem_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Tag and data arrays carry no reset; valid_q alone qualifies them.
  always_ff @(posedge clk) begin
    if (!rst && state_q == FILL && mem_ready) begin
      tag_q[idx]  <= tg;
      data_q[idx] <= mem_line;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= '0;
      req_addr   <= '0;
      cpu_ready  <= 1'b0;
      cpu_data   <= '0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      cpu_ready <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (flush)        valid_q  <= '0;
          else if (cpu_req) req_addr <= cpu_addr;
        end
        LOOKUP: begin
          if (hit) begin
            cpu_data  <= pick(data_q[idx], wsel);
            cpu_ready <= 1'b1;
            if (hit_count != '1) hit_count <= hit_count + 1'b1;
          end else begin
            mem_req  <= 1'b1;
            mem_addr <= {req_addr[31:4], 4'b0000};
            if (miss_count != '1) miss_count <= miss_count + 1'b1;
          end
        end
        FILL: begin
          if (mem_ready) begin
            valid_q[idx] <= 1'b1;
            cpu_data     <= pick(mem_line, wsel);
            cpu_ready    <= 1'b1;
            mem_req      <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_icache_controller.sv
// Directed and random fetch traffic against a line-slot model of the cache.
// Two instances share stimulus: default counters and 2-bit saturating counters.
module tb_icache_controller;

  logic         clk = 1'b0;
  logic         rst;
  logic         cpu_req;
  logic [31:0]  cpu_addr;
  logic         flush;
  logic         mem_ready;
  logic [127:0] mem_line;

  logic         cpu_ready, cpu_ready2;
  logic [31:0]  cpu_data, cpu_data2;
  logic         mem_req, mem_req2;
  logic [31:0]  mem_addr, mem_addr2;
  logic [15:0]  hit_count, miss_count;
  logic [1:0]   hit2, miss2;

  int passed = 0;
  int total  = 0;

  // Model: which memory line (addr>>4) occupies each slot.
  bit          mv [16];
  logic [27:0] ml [16];
  int          mh, mm;
  logic [31:0] last_data;

  always #5 clk = ~clk;

  icache_controller #(.INDEX_BITS(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_addr(cpu_addr),
    .cpu_ready(cpu_ready), .cpu_data(cpu_data), .flush(flush),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready),
    .mem_line(mem_line), .hit_count(hit_count), .miss_count(miss_count)
  );

  icache_controller #(.INDEX_BITS(4), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_addr(cpu_addr),
    .cpu_ready(cpu_ready2), .cpu_data(cpu_data2), .flush(flush),
    .mem_req(mem_req2), .mem_addr(mem_addr2), .mem_ready(mem_ready),
    .mem_line(mem_line), .hit_count(hit2), .miss_count(miss2)
  );

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [7:0] mbyte(input logic [31:0] a);
    return a[7:0] ^ a[15:8];
  endfunction

  function automatic logic [127:0] mline(input logic [31:0] base);
    logic [127:0] l;
    for (int b = 0; b < 16; b++) l[8*b +: 8] = mbyte(base + b);
    return l;
  endfunction

  function automatic logic [31:0] mword(input logic [31:0] a);
    logic [31:0] w0;
    w0 = {a[31:2], 2'b00};
    return {mbyte(w0 + 3), mbyte(w0 + 2), mbyte(w0 + 1), mbyte(w0)};
  endfunction

  function automatic int sat(input int c, input int w);
    int m;
    m = (1 << w) - 1;
    return (c > m) ? m : c;
  endfunction

  task automatic chk_cnt(input string tag);
    chk({tag, "_hit"},   hit_count,  sat(mh, 16));
    chk({tag, "_miss"},  miss_count, sat(mm, 16));
    chk({tag, "_hit2"},  hit2,       sat(mh, 2));
    chk({tag, "_miss2"}, miss2,      sat(mm, 2));
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) mv[i] = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge where the response is visible.
  task automatic access(input logic [31:0] a, input int lat);
    logic [31:0] la;
    int          ix;
    bit          h;
    la = {a[31:4], 4'b0000};
    ix = int'(a[7:4]);
    h  = mv[ix] && (ml[ix] == a[31:4]);
    cpu_req  = 1'b1;
    cpu_addr = a;
    @(negedge clk);
    cpu_req  = 1'b0;
    cpu_addr = $urandom;
    chk("lookup_ready", cpu_ready, 1'b0);
    chk("hold_data", cpu_data, last_data);
    @(negedge clk);
    if (h) begin
      mh++;
      chk("hit_ready", cpu_ready, 1'b1);
      chk("hit_data", cpu_data, mword(a));
      chk("hit_memreq", mem_req, 1'b0);
    end else begin
      mm++;
      chk("miss_memreq", mem_req, 1'b1);
      chk("miss_addr", mem_addr, la);
      chk("miss_ready", cpu_ready, 1'b0);
      for (int i = 0; i < lat; i++) begin
        @(negedge clk);
        chk("wait_memreq", mem_req, 1'b1);
        chk("wait_addr", mem_addr, la);
        chk("wait_ready", cpu_ready, 1'b0);
      end
      mem_ready = 1'b1;
      mem_line  = mline(la);
      @(negedge clk);
      mem_ready = 1'b0;
      mem_line  = {4{$urandom}};
      chk("fill_ready", cpu_ready, 1'b1);
      chk("fill_data", cpu_data, mword(a));
      chk("fill_memreq", mem_req, 1'b0);
      mv[ix] = 1'b1;
      ml[ix] = a[31:4];
    end
    last_data = mword(a);
    chk_cnt("acc");
  endtask

  task automatic flush_with_req(input logic [31:0] a);
    flush    = 1'b1;
    cpu_req  = 1'b1;
    cpu_addr = a;
    @(negedge clk);
    flush   = 1'b0;
    cpu_req = 1'b0;
    chk("flush_ready0", cpu_ready, 1'b0);
    @(negedge clk);
    chk("flush_ready1", cpu_ready, 1'b0);
    chk("flush_memreq", mem_req, 1'b0);
    model_clear();
    chk_cnt("flush");
  endtask

  function automatic logic [31:0] rand_addr();
    return {22'd0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15))};
  endfunction

  initial begin
    rst = 1'b1; cpu_req = 1'b0; cpu_addr = '0; flush = 1'b0;
    mem_ready = 1'b0; mem_line = '0;
    mh = 0; mm = 0; last_data = '0;
    model_clear();
    repeat (3) @(negedge clk);
    chk("rst_ready", cpu_ready, 1'b0);
    chk("rst_data", cpu_data, 32'h0);
    chk("rst_memreq", mem_req, 1'b0);
    chk("rst_memaddr", mem_addr, 32'h0);
    rst = 1'b0;
    chk_cnt("rst");

    access(32'h24, 4);
    chk("cold_word", cpu_data, 32'h27262524);
    access(32'h28, 0);
    chk("hit_word", cpu_data, 32'h2B2A2928);

    access(32'h124, 2);
    access(32'h024, 1);
    access(32'h024, 0);

    flush_with_req(32'h28);
    access(32'h28, 3);

    // Reset two cycles into a fill.
    cpu_req = 1'b1; cpu_addr = 32'h300;
    @(negedge clk);
    cpu_req = 1'b0;
    @(negedge clk);
    chk("mid_memreq", mem_req, 1'b1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstfill_memreq", mem_req, 1'b0);
    chk("rstfill_ready", cpu_ready, 1'b0);
    mh = 0; mm = 0; last_data = '0;
    model_clear();
    chk_cnt("rstfill");
    mem_ready = 1'b1; mem_line = mline(32'h300);
    @(negedge clk);
    mem_ready = 1'b0;
    chk("late_ready", cpu_ready, 1'b0);
    @(negedge clk);
    chk("late_ready2", cpu_ready, 1'b0);
    access(32'h28, 1);

    access(32'h40, 0);
    for (int i = 0; i < 5; i++) access(32'h40 + 4 * (i % 4), 0);
    chk("sat_hit2", hit2, 2'd3);

    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 9) == 0) flush_with_req(rand_addr());
      else access(rand_addr(), $urandom_range(0, 4));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/icache_controller.md
Name: icache_controller

Overview:
- Direct-mapped instruction cache controller between the fetch stage and the 128-bit line instruction memory.
- Holds tag, valid and data arrays internally, with 16-byte lines.
- Serves 32-bit word requests from the fetch stage.
- On a miss, sequences a line fill from the slow memory through a req/ready handshake, then returns the word.
- Keeps hit and miss statistics counters.

Parameters:
- INDEX_BITS, 4, number of index bits; the cache has 2^INDEX_BITS lines.
- CNT_W, 16, width of the hit and miss statistics counters.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- cpu_req  input  1  fetch request; sampled only in IDLE.
- cpu_addr  input  32  byte address; sampled with cpu_req; bits [1:0] ignored.
- cpu_ready  output  1  registered one-cycle pulse; cpu_data is valid in that cycle.
- cpu_data  output  32  fetched word; holds its value until the next cpu_ready.
- flush  input  1  level signal; invalidates all lines; acted on only in IDLE.
- mem_req  output  1  line fill request; held high until mem_ready.
- mem_addr  output  32  line address {tag,index,4'b0000}; stable while mem_req=1.
- mem_ready  input  1  one-cycle pulse; mem_line is valid in that cycle.
- mem_line  input  128  fill data; byte b of the line is mem_line[8b+7:8b].
- hit_count  output  CNT_W  number of hits; saturating.
- miss_count  output  CNT_W  number of misses; saturating.

Behaviour:
- Address split:
  - offset = addr[3:0]; word select w = addr[3:2].
  - index = addr[4+INDEX_BITS-1:4].
  - tag = addr[31:4+INDEX_BITS].
  - Returned word = line[32w+31:32w].
- Reset (applies at any time, including mid-fill):
  - state=IDLE; all valid bits=0.
  - cpu_ready=0, cpu_data=0, mem_req=0, mem_addr=0.
  - hit_count=0, miss_count=0.
  - Tag and data arrays need no reset.
- FSM states: IDLE, LOOKUP, FILL.
- IDLE:
  - If flush=1: clear all valid bits in one cycle and stay in IDLE. cpu_req is ignored that cycle; flush has priority.
  - Else if cpu_req=1: latch cpu_addr into req_addr and go to LOOKUP.
- LOOKUP, hit (valid[index] and tag matches):
  - cpu_data <= selected word; cpu_ready <= 1.
  - hit_count += 1 (saturating); go to IDLE.
- LOOKUP, miss:
  - mem_req <= 1; mem_addr <= {req_addr[31:4],4'b0}.
  - miss_count += 1 (saturating); go to FILL.
- FILL:
  - Wait for mem_ready=1.
  - On mem_ready: write mem_line to data[index], tag to tag[index], set valid[index].
  - In the same edge: cpu_data <= word from mem_line (not from the array); cpu_ready <= 1; mem_req <= 0; go to IDLE.
- Latency: request sampled at edge k.
  - Hit: cpu_ready is high in the cycle after edge k+1.
  - Miss: cpu_ready is high in the cycle after the edge that samples mem_ready.
- cpu_ready is 0 in every cycle other than those response pulses.
- Back-to-back: cpu_req high during the cpu_ready cycle is accepted, because the FSM is already in IDLE.
- Ignored inputs:
  - cpu_req and cpu_addr outside IDLE.
  - mem_ready outside FILL.
  - flush outside IDLE; it takes effect once the FSM returns to IDLE if still asserted.
- Conflict miss: the new line overwrites the old line at the same index with no writeback, since the cache is read-only.
- Counters: saturate at all-ones with no wrap. Cleared only by rst, not by flush.

Test Plan:
- Cold miss:
  - Stimulus: after rst, memory byte i = i[7:0] with 4-cycle latency; request 0x24.
  - Required: mem_req high with mem_addr=0x20 until mem_ready. Then cpu_ready=1 with cpu_data=0x27262524; miss_count=1.
- Hit:
  - Stimulus: next request 0x28.
  - Required: no mem_req; cpu_ready exactly 2 cycles after cpu_req is sampled; cpu_data=0x2B2A2928; hit_count=1.
- Conflict:
  - Stimulus: INDEX_BITS=4; request 0x124, then 0x024.
  - Required: both miss, with mem_addr=0x120 then 0x020; miss_count increments on each; the following request to 0x024 hits.
- Flush priority:
  - Stimulus: flush=1 and cpu_req=1 together in IDLE for one cycle; then request 0x28.
  - Required: no cpu_ready for the overlapped cycle; the 0x28 request misses; hit_count is unchanged by the flush.
- Reset mid-fill:
  - Stimulus: assert rst 2 cycles into a FILL.
  - Required: mem_req=0 next cycle; counters=0. A late mem_ready is ignored (no cpu_ready); the next request misses.
- Saturation:
  - Stimulus: CNT_W=2; issue 5 hits to one line.
  - Required: hit_count stays at 3.
